// File: rtl/bus_mem_responder_if.sv
// Request/response bus between a line requester (master) and the memory responder (slave).
interface bus_mem_responder_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Line-oriented memory responder: accepts a tagged line address, then either
// streams BEATS read beats after a fixed latency or absorbs BEATS write beats.
module bus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned BEATS          = 8,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic               clk,
  input  logic               reset,
  bus_mem_responder_if.slave bus,
  output logic               busy
);
  localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_WDATA = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_reqack, w_reqack_nxt;
  logic                      r_gap, w_gap_nxt;
  logic [ADDR_W-1:0]         r_idx, w_idx_nxt;
  logic [BUS_TAG_WIDTH-1:0]  r_tag, w_tag_nxt;
  logic [BEAT_W-1:0]         r_beat, w_beat_nxt;
  logic [LAT_W-1:0]          r_lat, w_lat_nxt;
  logic                      r_respcyc, w_respcyc_nxt;
  logic [BUS_TAG_WIDTH-1:0]  r_resptag, w_resptag_nxt;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic                      r_busy;
  logic                      w_load_resp, w_clear_resp, w_mem_we, w_accept;
  logic [ADDR_W-1:0]         w_rd_addr, w_wr_addr, w_idx;

  logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // Line base word index: byte address with the 64-byte offset dropped, modulo memory size.
  assign w_idx = {bus.bus_req[ADDR_W+2:6], 3'b000};

  // A held request is never taken in the cycle that shows its ack.
  assign w_accept = bus.bus_reqcyc && !r_reqack;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_reqack_nxt  = 1'b0;
    w_gap_nxt     = 1'b0;
    w_idx_nxt     = r_idx;
    w_tag_nxt     = r_tag;
    w_beat_nxt    = r_beat;
    w_lat_nxt     = r_lat;
    w_respcyc_nxt = r_respcyc;
    w_resptag_nxt = r_resptag;
    w_load_resp   = 1'b0;
    w_clear_resp  = 1'b0;
    w_mem_we      = 1'b0;
    w_rd_addr     = r_idx + ADDR_W'(r_beat);
    w_wr_addr     = r_idx + ADDR_W'(r_beat);
    case (r_state)
      S_IDLE: begin
        if (w_accept && !r_gap) begin
          w_reqack_nxt = 1'b1;
          w_idx_nxt    = w_idx;
          w_tag_nxt    = bus.bus_reqtag;
          w_beat_nxt   = '0;
          w_lat_nxt    = '0;
          w_state_nxt  = bus.bus_reqtag[BUS_TAG_WIDTH-1] ? S_WAIT : S_WDATA;
        end
      end
      S_WAIT: begin
        if (r_lat == LAT_W'(READ_LATENCY - 1)) begin
          w_state_nxt   = S_RESP;
          w_beat_nxt    = '0;
          w_respcyc_nxt = 1'b1;
          w_resptag_nxt = r_tag;
          w_load_resp   = 1'b1;
          w_rd_addr     = r_idx;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.bus_respack) begin
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            w_state_nxt   = S_IDLE;
            w_gap_nxt     = 1'b1;
            w_respcyc_nxt = 1'b0;
            w_resptag_nxt = '0;
            w_clear_resp  = 1'b1;
          end else begin
            w_beat_nxt  = r_beat + BEAT_W'(1);
            w_load_resp = 1'b1;
            w_rd_addr   = r_idx + ADDR_W'(r_beat) + ADDR_W'(1);
          end
        end
      end
      S_WDATA: begin
        if (w_accept) begin
          w_mem_we     = 1'b1;
          w_reqack_nxt = 1'b1;
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = 1'b1;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reqack  <= 1'b0;
      r_gap     <= 1'b0;
      r_idx     <= '0;
      r_tag     <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
      r_respcyc <= 1'b0;
      r_resptag <= '0;
      r_resp    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_reqack  <= w_reqack_nxt;
      r_gap     <= w_gap_nxt;
      r_idx     <= w_idx_nxt;
      r_tag     <= w_tag_nxt;
      r_beat    <= w_beat_nxt;
      r_lat     <= w_lat_nxt;
      r_respcyc <= w_respcyc_nxt;
      r_resptag <= w_resptag_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_load_resp)       r_resp <= r_mem[w_rd_addr];
      else if (w_clear_resp) r_resp <= '0;
    end
  end

  // Backing store survives reset; a beat arriving alongside reset is dropped.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) r_mem[w_wr_addr] <= bus.bus_req;
  end

  assign bus.bus_reqack  = r_reqack;
  assign bus.bus_respcyc = r_respcyc;
  assign bus.bus_resp    = r_resp;
  assign bus.bus_resptag = r_resptag;
  assign busy            = r_busy;
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: line writes, reads, stalls, wrap, reset and spacing.
module tb_bus_mem_responder;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 13;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Observations filled in by the requester tasks
  logic [DW-1:0] rd_data [8];
  int   rd_n, rd_lat, rd_ack_wait, rd_tag_bad, rd_stall_bad, rd_extra_acks;
  bit   rd_timeout;
  logic rd_after, rd_busy_after;
  int   wr_acks, wr_ack_wait;
  bit   wr_timeout;
  logic wr_busy_after;

  bus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus ();

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(4096), .BEATS(8), .READ_LATENCY(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bus.bus_reqcyc = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Requester for a write line: address, then 8 data beats base+0..base+7.
  task automatic write_line(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                            input logic [DW-1:0] base);
    int item, start, tail;
    bit adv;
    item = 0; adv = 0; tail = 0;
    wr_acks = 0; wr_ack_wait = -1; wr_timeout = 1; wr_busy_after = 1'bx;
    bus.bus_reqcyc = 1'b1; bus.bus_req = addr; bus.bus_reqtag = tag;
    start = cyc;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (adv) begin
        item++; adv = 0;
        if (item <= 8) bus.bus_req = base + DW'(item - 1);
        else begin bus.bus_reqcyc = 1'b0; wr_busy_after = busy; end
      end
      if (bus.bus_reqack) begin
        wr_acks++; adv = 1;
        if (wr_ack_wait < 0) wr_ack_wait = cyc - start;
      end
      if (item > 8) begin
        tail++;
        if (tail > 3) begin wr_timeout = 0; break; end
      end
    end
    bus.bus_reqcyc = 1'b0;
  endtask

  // Requester for a read line; optional stall on one beat, bus noise in RESP, reset on a beat.
  task automatic read_line(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                           input int stall_beat, input int stall_len,
                           input bit noise, input int reset_beat);
    int start, ack_cyc, stalled;
    bit done;
    logic [DW-1:0] hold;
    for (int i = 0; i < 8; i++) rd_data[i] = 64'hDEAD_BEEF;
    rd_n = 0; rd_lat = -1; rd_ack_wait = -1; rd_tag_bad = 0; rd_stall_bad = 0;
    rd_extra_acks = 0; rd_timeout = 1; rd_after = 1'bx; rd_busy_after = 1'bx;
    hold = '0; stalled = 0; done = 0; ack_cyc = -1;
    bus.bus_reqcyc = 1'b1; bus.bus_req = addr; bus.bus_reqtag = tag; bus.bus_respack = 1'b1;
    start = cyc;
    for (int k = 0; k < 40 && ack_cyc < 0; k++) begin
      tick();
      if (bus.bus_reqack) ack_cyc = cyc;
    end
    if (ack_cyc < 0) begin bus.bus_reqcyc = 1'b0; return; end
    rd_ack_wait = ack_cyc - start;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      bus.bus_reqcyc = 1'b0;
      if (bus.bus_reqack) rd_extra_acks++;
      if (bus.bus_respcyc) begin
        if (rd_lat < 0) rd_lat = cyc - ack_cyc;
        if (bus.bus_resptag !== tag) rd_tag_bad++;
        if (noise) begin
          bus.bus_reqcyc = 1'b1; bus.bus_req = 64'h40000; bus.bus_reqtag = 13'h1FFF;
        end
        if (rd_n == reset_beat) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          rd_after = bus.bus_respcyc; rd_busy_after = busy;
          done = 1;
        end else if (rd_n == stall_beat && stalled < stall_len) begin
          bus.bus_respack = 1'b0;
          if (stalled == 0) hold = bus.bus_resp;
          else if (bus.bus_resp !== hold) rd_stall_bad++;
          stalled++;
        end else begin
          if (stalled > 0 && rd_n == stall_beat && bus.bus_resp !== hold) rd_stall_bad++;
          bus.bus_respack = 1'b1;
          rd_data[rd_n] = bus.bus_resp;
          rd_n++;
          if (rd_n == 8) begin
            bus.bus_reqcyc = 1'b0;
            tick();
            if (bus.bus_reqack) rd_extra_acks++;
            rd_after = bus.bus_respcyc;
            done = 1;
          end
        end
      end
    end
    if (done) rd_timeout = 0;
    bus.bus_reqcyc = 1'b0;
    bus.bus_respack = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.bus_reqcyc = 1'b0; bus.bus_req = '0; bus.bus_reqtag = '0; bus.bus_respack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.bus_reqack !== 1'b0) begin errors++; $display("FAIL reset_reqack: got %b expected 0", bus.bus_reqack); end
    checks++; if (bus.bus_respcyc !== 1'b0) begin errors++; $display("FAIL reset_respcyc: got %b expected 0", bus.bus_respcyc); end
    checks++; if (bus.bus_resp !== 64'h0) begin errors++; $display("FAIL reset_resp: got %h expected 0", bus.bus_resp); end
    checks++; if (bus.bus_resptag !== 13'h0) begin errors++; $display("FAIL reset_resptag: got %h expected 0", bus.bus_resptag); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    write_line(64'h1000, 13'h0005, 64'hA0);
    checks++; if (wr_timeout) begin errors++; $display("FAIL write_timeout: got acks=%0d expected 9", wr_acks); end
    checks++; if (wr_acks !== 9) begin errors++; $display("FAIL write_acks: got %0d expected 9", wr_acks); end
    checks++; if (wr_ack_wait !== 1) begin errors++; $display("FAIL write_ack_wait: got %0d expected 1", wr_ack_wait); end
    checks++; if (wr_busy_after !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b expected 0", wr_busy_after); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut.r_mem[12'h200 + i] !== 64'hA0 + 64'(i)) begin
        errors++; $display("FAIL write_mem[%0d]: got %h expected %h", i, dut.r_mem[12'h200 + i], 64'hA0 + 64'(i));
      end
    end
    idle(2);
  endtask

  task automatic test_read();
    read_line(64'h1010, 13'h1005, -1, 0, 0, -1);
    checks++; if (rd_timeout) begin errors++; $display("FAIL read_timeout: got beats=%0d expected 8", rd_n); end
    checks++; if (rd_lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", rd_lat); end
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL read_beats: got %0d expected 8", rd_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'hA0 + 64'(i)) begin
        errors++; $display("FAIL read_beat%0d: got %h expected %h", i, rd_data[i], 64'hA0 + 64'(i));
      end
    end
    checks++; if (rd_tag_bad !== 0) begin errors++; $display("FAIL read_resptag: got %0d bad beats expected 0", rd_tag_bad); end
    checks++; if (rd_after !== 1'b0) begin errors++; $display("FAIL read_respcyc_drop: got %b expected 0", rd_after); end
    idle(2);
  endtask

  task automatic test_stall();
    read_line(64'h1000, 13'h1123, 2, 3, 0, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL stall_beats: got %0d expected 8", rd_n); end
    checks++; if (rd_stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d changed cycles expected 0", rd_stall_bad); end
    checks++; if (rd_tag_bad !== 0) begin errors++; $display("FAIL stall_resptag: got %0d bad beats expected 0", rd_tag_bad); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'hA0 + 64'(i)) begin
        errors++; $display("FAIL stall_beat%0d: got %h expected %h", i, rd_data[i], 64'hA0 + 64'(i));
      end
    end
    idle(2);
  endtask

  task automatic test_wrap();
    write_line(64'h3FFC0, 13'h0FFF, 64'hB0);
    idle(2);
    write_line(64'h0, 13'h0001, 64'hC0);
    idle(2);
    checks++; if (dut.r_mem[12'hFF8] !== 64'hB0) begin errors++; $display("FAIL wrap_index_ff8: got %h expected b0", dut.r_mem[12'hFF8]); end
    read_line(64'h3FFC0, 13'h1ABC, -1, 0, 0, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL wrap_top_beats: got %0d expected 8", rd_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'hB0 + 64'(i)) begin
        errors++; $display("FAIL wrap_top_beat%0d: got %h expected %h", i, rd_data[i], 64'hB0 + 64'(i));
      end
    end
    idle(2);
    read_line(64'h40000, 13'h1001, -1, 0, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'hC0 + 64'(i)) begin
        errors++; $display("FAIL wrap_alias_beat%0d: got %h expected %h", i, rd_data[i], 64'hC0 + 64'(i));
      end
    end
    idle(2);
  endtask

  task automatic test_read_after_write();
    write_line(64'h1000, 13'h0002, 64'hD0);
    read_line(64'h1038, 13'h1002, -1, 0, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_data[i] !== 64'hD0 + 64'(i)) begin
        errors++; $display("FAIL raw_beat%0d: got %h expected %h", i, rd_data[i], 64'hD0 + 64'(i));
      end
    end
    idle(2);
  endtask

  task automatic test_reqcyc_in_resp();
    read_line(64'h1000, 13'h1010, -1, 0, 1, -1);
    checks++; if (rd_extra_acks !== 0) begin errors++; $display("FAIL resp_noise_acks: got %0d expected 0", rd_extra_acks); end
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL resp_noise_beats: got %0d expected 8", rd_n); end
    checks++; if (rd_data[7] !== 64'hD7) begin errors++; $display("FAIL resp_noise_last: got %h expected d7", rd_data[7]); end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    read_line(64'h0, 13'h1020, -1, 0, 0, 4);
    checks++; if (rd_after !== 1'b0) begin errors++; $display("FAIL midreset_respcyc: got %b expected 0", rd_after); end
    checks++; if (rd_busy_after !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", rd_busy_after); end
    checks++; if (rd_n !== 4) begin errors++; $display("FAIL midreset_beats: got %0d expected 4", rd_n); end
    checks++; if (rd_data[3] !== 64'hC3) begin errors++; $display("FAIL midreset_beat3: got %h expected c3", rd_data[3]); end
    idle(1);
    read_line(64'h1000, 13'h1021, -1, 0, 0, -1);
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL postreset_beats: got %0d expected 8", rd_n); end
    checks++; if (rd_data[0] !== 64'hD0 || rd_data[7] !== 64'hD7) begin
      errors++; $display("FAIL postreset_data: got %h..%h expected d0..d7", rd_data[0], rd_data[7]);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    read_line(64'h3FFC0, 13'h1030, -1, 0, 0, -1);
    read_line(64'h0, 13'h1031, -1, 0, 0, -1);
    checks++; if (rd_ack_wait !== 2) begin errors++; $display("FAIL b2b_ack_wait: got %0d expected 2", rd_ack_wait); end
    checks++; if (rd_n !== 8) begin errors++; $display("FAIL b2b_beats: got %0d expected 8", rd_n); end
    checks++; if (rd_data[5] !== 64'hC5) begin errors++; $display("FAIL b2b_beat5: got %h expected c5", rd_data[5]); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_wrap();
    test_read_after_write();
    test_reqcyc_in_resp();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
